// File: rtl/demux_stream.sv
// demux_stream: 1-to-NCH valid/ready stream demultiplexer with one holding slot per channel
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     producer handshake; in_data payload, in_sel destination channel
//   out_valid/out_ready   per-channel consumer handshake (bit k = channel k)
//   out_data              channel k payload at [k*DW +: DW]
//   err, err_clr          sticky illegal-select flag and its clear (only with DEMUX_STREAM_ERR_EN)
module demux_stream #(
  parameter int DW   = 8,
  parameter int NCH  = 8,
  parameter int SELW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef DEMUX_STREAM_ERR_EN
  input  logic              err_clr,
  output logic              err,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  input  logic [SELW-1:0]   in_sel,
  output logic [NCH-1:0]    out_valid,
  input  logic [NCH-1:0]    out_ready,
  output logic [NCH*DW-1:0] out_data
);
  localparam int NP = 1 << SELW;
  logic [NCH-1:0]    valid_q, valid_d, hit, load;
  logic [NCH*DW-1:0] data_q, data_d;
  logic [NP-1:0]     full_p, rdy_p;
  // Padding the slot state out to every select code makes illegal selects look EMPTY,
  // so they are always ready and their words fall on the floor.
  assign full_p   = NP'(valid_q);
  assign rdy_p    = NP'(out_ready);
  assign in_ready = ~full_p[in_sel] | rdy_p[in_sel];
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      hit[k]             = in_sel == SELW'(k);
      load[k]            = in_valid & in_ready & hit[k];
      valid_d[k]         = load[k] | (valid_q[k] & ~out_ready[k]);
      data_d[k*DW +: DW] = load[k] ? in_data : data_q[k*DW +: DW];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  assign out_valid = valid_q;
  assign out_data  = data_q;
`ifdef DEMUX_STREAM_ERR_EN
  logic err_q, err_d;
  // Set has priority over clear.
  assign err_d = (in_valid & ~|hit) | (err_q & ~err_clr);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  assign err = err_q;
`endif
endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream: directed self-checking bench for demux_stream (NCH=8 and NCH=5 instances)
module tb_demux_stream;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv, ir;
  logic [7:0]  id;
  logic [2:0]  is;
  logic [7:0]  ov, ordy;
  logic [63:0] od;
  logic        iv5, ir5;
  logic [7:0]  id5;
  logic [2:0]  is5;
  logic [4:0]  ov5, ordy5;
  logic [39:0] od5;
  int total = 0, bad = 0;
  int hs10 = 0;
  logic [7:0] got[$];
`ifdef DEMUX_STREAM_ERR_EN
  logic ec, er, ec5, er5;
`endif

  always #5 clk = ~clk;

  demux_stream #(.DW(8), .NCH(8), .SELW(3)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef DEMUX_STREAM_ERR_EN
    .err_clr(ec), .err(er),
`endif
    .in_valid(iv), .in_ready(ir), .in_data(id), .in_sel(is),
    .out_valid(ov), .out_ready(ordy), .out_data(od));

  demux_stream #(.DW(8), .NCH(5), .SELW(3)) dut5 (
    .clk(clk), .rst_n(rst_n),
`ifdef DEMUX_STREAM_ERR_EN
    .err_clr(ec5), .err(er5),
`endif
    .in_valid(iv5), .in_ready(ir5), .in_data(id5), .in_sel(is5),
    .out_valid(ov5), .out_ready(ordy5), .out_data(od5));

  always @(posedge clk) begin
    if (rst_n && ov[2] && ordy[2] && od[23:16] == 8'h10) hs10++;
    if (rst_n && ov[0] && ordy[0]) got.push_back(od[7:0]);
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("reset_valid", 64'(ov), 64'h00);
    chk("reset_data", od, 64'h0);
    chk("reset_valid5", 64'(ov5), 64'h00);
    @(negedge clk);
    rst_n = 1'b1;
    iv = 1'b1; is = 3'd3; id = 8'hA5; ordy = 8'h00;
    #1 chk("cold_ready", 64'(ir), 64'd1);
    cyc();
    chk("cold_valid", 64'(ov), 64'h08);
    chk("cold_data3", 64'(od[31:24]), 64'hA5);
    id = 8'h77;
    #1 chk("full_ready", 64'(ir), 64'd0);
    iv = 1'b0;
    cyc();
    chk("full_keep", 64'(od[31:24]), 64'hA5);
  endtask

  task automatic test_isolation();
    iv = 1'b1; is = 3'd5; id = 8'h11; ordy = 8'h20;
    #1 chk("iso_ready", 64'(ir), 64'd1);
    cyc();
    iv = 1'b0;
    chk("iso_valid", 64'(ov), 64'h28);
    chk("iso_data5", 64'(od[47:40]), 64'h11);
    chk("iso_data3", 64'(od[31:24]), 64'hA5);
    cyc();
    chk("iso_drain5", 64'(ov), 64'h08);
    ordy = 8'h08;
    cyc();
    chk("iso_drain3", 64'(ov), 64'h00);
  endtask

  task automatic test_drain_load();
    ordy = 8'h00; iv = 1'b1; is = 3'd2; id = 8'h10;
    cyc();
    chk("dl_first", 64'(od[23:16]), 64'h10);
    hs10 = 0;
    ordy = 8'h04; id = 8'h20;
    #1 chk("dl_ready", 64'(ir), 64'd1);
    cyc();
    iv = 1'b0; ordy = 8'h00;
    chk("dl_valid", 64'(ov), 64'h04);
    chk("dl_data", 64'(od[23:16]), 64'h20);
    ordy = 8'h04;
    cyc();
    chk("dl_hs10", 64'(hs10), 64'd1);
    chk("dl_empty", 64'(ov), 64'h00);
  endtask

  task automatic test_stream();
    got.delete();
    ordy = 8'h01; iv = 1'b1; is = 3'd0;
    for (int i = 0; i < 16; i++) begin
      id = 8'(i);
      #1 if (ir !== 1'b1) chk("stream_ready", 64'(ir), 64'd1);
      cyc();
    end
    iv = 1'b0;
    chk("stream_mid_count", 64'(got.size()), 64'd15);
    cyc();
    chk("stream_count", 64'(got.size()), 64'd16);
    for (int i = 0; i < 16 && i < got.size(); i++)
      chk("stream_word", 64'(got[i]), 64'(i));
    chk("stream_empty", 64'(ov), 64'h00);
  endtask

  task automatic test_illegal();
    iv5 = 1'b1; is5 = 3'd1; id5 = 8'h3C; ordy5 = 5'h00;
    cyc();
    chk("ill_pre", 64'(ov5), 64'h02);
    is5 = 3'd6; id5 = 8'hFF;
    #1 chk("ill_ready6", 64'(ir5), 64'd1);
    cyc();
    chk("ill_valid6", 64'(ov5), 64'h02);
    chk("ill_data", od5, 64'h00_0000_3C00);
`ifdef DEMUX_STREAM_ERR_EN
    chk("ill_err_set", 64'(er5), 64'd1);
    iv5 = 1'b0; ec5 = 1'b1;
    cyc();
    chk("ill_err_clr", 64'(er5), 64'd0);
    ec5 = 1'b0; iv5 = 1'b1;
`endif
    is5 = 3'd5; id5 = 8'hEE;
    #1 chk("ill_ready5", 64'(ir5), 64'd1);
    cyc();
    chk("ill_valid5", 64'(ov5), 64'h02);
    is5 = 3'd4; id5 = 8'h44;
    cyc();
    iv5 = 1'b0;
    chk("ill_legal4", 64'(ov5), 64'h12);
    chk("ill_data4", 64'(od5[39:32]), 64'h44);
  endtask

  task automatic test_midreset();
    ordy = 8'h00; iv = 1'b1;
    is = 3'd0; id = 8'h01; cyc();
    is = 3'd1; id = 8'h02; cyc();
    is = 3'd6; id = 8'h03; cyc();
    iv = 1'b0;
    chk("mr_full", 64'(ov), 64'h43);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", 64'(ov), 64'h00);
    chk("mr_data", od, 64'h0);
    chk("mr_valid5", 64'(ov5), 64'h00);
    chk("mr_ready", 64'(ir), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    iv = 1'b1; is = 3'd6; id = 8'h5A;
    cyc();
    iv = 1'b0;
    chk("mr_cold", 64'(ov), 64'h40);
    chk("mr_cold_data", 64'(od[55:48]), 64'h5A);
  endtask

  initial begin
    iv = 1'b0; id = '0; is = '0; ordy = '0;
    iv5 = 1'b0; id5 = '0; is5 = '0; ordy5 = '0;
`ifdef DEMUX_STREAM_ERR_EN
    ec = 1'b0; ec5 = 1'b0;
`endif
    test_reset();
    test_isolation();
    test_drain_load();
    test_stream();
    test_illegal();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/demux_stream.md
# demux_stream

Parametrised 1-to-NCH stream demultiplexer with valid/ready handshaking and one registered holding slot per output channel. It is the successor to the 1-to-8 combinational demultiplexer: multi-bit data in place of a single bit, any channel count, and per-channel back-pressure. It routes a single producer to NCH independent consumers in lab datapaths, such as LED/7-seg drivers and UART transmit slots. It absorbs consumer stalls without corrupting other channels.

## Interface
Parameters:
- DW, 8, data width in bits (≥1)
- NCH, 8, number of output channels (2..16, need not be a power of two)
- SELW, 3, select width; must satisfy 2^SELW ≥ NCH

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous reset, active-low
- in_valid  input  1  producer has a word
- in_ready  output  1  block accepts the word this cycle
- in_data  input  DW  payload
- in_sel  input  SELW  destination channel, qualified by in_valid
- out_valid  output  NCH  bit k: channel k slot holds a word
- out_ready  input  NCH  bit k: consumer k takes the word this cycle
- out_data  output  NCH*DW  channel k payload at bits [k*DW +: DW]

## Operation
- Each channel k has a slot with two states: EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
- Legal select: in_sel < NCH.
- in_ready = 1 when either of these holds:
  - in_sel is illegal;
  - the slot of in_sel is EMPTY or out_ready[in_sel] = 1.
- in_ready is combinational from in_sel, slot state and out_ready. It does not depend on in_valid.
- Accept = in_valid & in_ready.
- Accept with legal in_sel = s: slot s loads in_data at the next edge and is FULL.
- Drain of channel k = out_valid[k] & out_ready[k]. The slot goes EMPTY at the next edge unless it is reloaded in the same cycle.
- Simultaneous drain and load on the same channel: the new word replaces the old one and out_valid stays 1. No bubble, no loss.
- Channels are independent. A stalled channel k never blocks a transfer to channel j≠k.
- Accept with illegal in_sel: the word is consumed and discarded, and no slot changes.
- out_data of an EMPTY slot holds its last value. Consumers must ignore it.
- A word is never duplicated and never dropped once accepted to a legal channel.

## Timing
- Latency: accept at edge n → out_valid[s]=1 and out_data[s] valid after edge n.
- Throughput: one word per cycle when the consumers keep out_ready high. A single channel sustains one word per cycle back-to-back.
- Reset (rst_n=0, asynchronous, effective immediately):
  - out_valid = 0;
  - out_data = 0;
  - err = 0, when present.
- While rst_n=0, in_ready follows its formula with all slots EMPTY. The bench must not rely on transfers during reset.
- Reset asserted mid-transfer: all buffered words are discarded. The first legal accept after release, on a rising edge with rst_n=1, behaves as from cold.
- No combinational path from in_valid or in_data to any output.
- The only combinational path is in_sel/out_ready → in_ready.

## Configuration
- DEMUX_STREAM_ERR_EN defined:
  - adds output port err (1 bit) and input port err_clr (1 bit);
  - err sets at the edge after an accept with illegal in_sel and is sticky;
  - err_clr=1 clears err at the next edge;
  - set and clear in the same cycle: set wins.
- DEMUX_STREAM_ERR_EN not defined:
  - ports err and err_clr are absent;
  - illegal-select words are still accepted and silently discarded.

## Test plan
- Reset and cold start:
  - stimulus: DW=8, NCH=8; pulse rst_n low mid-cycle; then in_valid=1, in_sel=3, in_data=0xA5, out_ready=0;
  - response: during reset out_valid=0x00 and out_data=0; after release, one edge later out_valid=0x08 and channel 3 data=0xA5;
  - the next word to channel 3 sees in_ready=0.
- Back-pressure isolation:
  - stimulus: channel 3 FULL with out_ready[3]=0; then send 0x11 to channel 5 with out_ready[5]=1;
  - response: in_ready=1, channel 5 receives 0x11, channel 3 still holds 0xA5.
- Same-cycle drain and load:
  - stimulus: channel 2 holds 0x10, out_ready[2]=1; send 0x20 to channel 2 in the same cycle;
  - response: after the edge out_valid[2]=1 and data=0x20; exactly one handshake of 0x10 is observed.
- Streaming:
  - stimulus: 16 consecutive words 0x00..0x0F to channel 0 with out_ready[0]=1 throughout;
  - response: in_ready stays 1 and the consumer sees 0x00..0x0F in order, one per cycle.
- Illegal select:
  - stimulus: NCH=5; send in_sel=6, in_data=0xFF;
  - response: in_ready=1, out_valid unchanged;
  - with DEMUX_STREAM_ERR_EN: err=1 one edge later; err_clr=1 clears it on the following edge.
- Mid-operation reset:
  - stimulus: 3 channels FULL; assert rst_n=0 asynchronously;
  - response: out_valid=0 immediately, without waiting for a clock edge.
